// File: rtl/digimic_pdm_transmitter.sv
// Stand-in digital microphone: buffers signed PCM samples in a small FIFO and emits a
// first-order sigma-delta PDM stream, one bit per DMCLK rise. Define PDM_DITHER_EN for LFSR dither.
module digimic_pdm_transmitter #(
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 12
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic                          DMCLK,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          DMDATA,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OSR);

    logic              dm_s1, dm_s2, dm_hist;
    logic              dm_step;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, fifo_empty, boundary;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] acc, cur_sample, cur_eff, u, u_mod;
    logic [DATA_W:0]   acc_next;

    // DMCLK is asynchronous: two sync flops, then a history flop for rise detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) {dm_hist, dm_s2, dm_s1} <= '0;
        else     {dm_hist, dm_s2, dm_s1} <= {dm_s2, dm_s1, DMCLK};
    end

    assign dm_step      = dm_s2 & ~dm_hist;
    assign fifo_empty   = (fifo_level == '0);
    assign sample_ready = (fifo_level != (AW+1)'(FIFO_DEPTH));
    assign push         = sample_valid & sample_ready;
    assign boundary     = dm_step & enable & (bit_cnt == '0);
    assign pop          = boundary & ~fifo_empty;

    // NOTE: the sample storage has no reset; emptiness is tracked by the pointers and level alone.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fifo_level <= fifo_level + (AW+1)'(1);
            else if (pop && !push) fifo_level <= fifo_level - (AW+1)'(1);
        end
    end

    // A sample popped at a boundary feeds the modulator in that same step.
    assign cur_eff = pop ? mem[rd_ptr] : cur_sample;
    // Adding 2^(DATA_W-1) to a two's-complement value just flips its sign bit.
    assign u       = {~cur_eff[DATA_W-1], cur_eff[DATA_W-2:0]};

`ifdef PDM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst)                    lfsr <= 16'hACE1;
        else if (enable && dm_step) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign u_mod = (&u) ? u : u + DATA_W'(lfsr[0]);
`else
    assign u_mod = u;
`endif

    assign acc_next = {1'b0, acc} + {1'b0, u_mod};

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            DMDATA     <= 1'b0;
            underrun   <= 1'b0;
            bit_cnt    <= '0;
            acc        <= '0;
            cur_sample <= '0;
        end else if (!enable) begin
            DMDATA  <= 1'b0;
            bit_cnt <= '0;
        end else if (dm_step) begin
            bit_cnt <= (bit_cnt == CW'(OSR - 1)) ? '0 : bit_cnt + CW'(1);
            acc     <= acc_next[DATA_W-1:0];
            DMDATA  <= acc_next[DATA_W];
            if (boundary) begin
                if (fifo_empty) underrun   <= 1'b1;
                else            cur_sample <= mem[rd_ptr];
            end
        end
    end

endmodule
